sha256_xmss_arbiter: RTL and testbench

Round-robin arbiter that shares one sha256XMSS hash core between N_REQ WOTS chain engines (gen_chain instances) so several chains can run in parallel without duplicating the SHA-256 datapath. Each requester sees the same hash_start / hash_data_in / message_length / hash_done / hash_data_out handshake it would see from a private core. The arbiter latches requests, grants the core to one requester at a time, and routes the digest back with a done pulse.

---
 rtl/sha_arb_pkg.sv | 20 ++
 rtl/sha256_xmss_arbiter_if.sv | 38 +++
 rtl/sha256_xmss_arbiter_rr_picker.sv | 25 ++
 rtl/sha256_xmss_arbiter.sv | 117 +++++++++++
 tb/tb_sha256_xmss_arbiter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha_arb_pkg.sv
// Shared definitions for the sha256XMSS hash-core arbiter: FSM encoding,
// datapath widths and the round-robin pointer helper.
package sha_arb_pkg;

  localparam int HASH_BLOCK_W = 1024;
  localparam int HASH_OUT_W   = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  // Index following idx, wrapping at n (n need not be a power of two).
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sha256_xmss_arbiter_if.sv
// Requester-side and core-side handshake bundle of the sha256XMSS arbiter.
// The arbiter uses the slave view; the environment drives the master view.
interface sha256_xmss_arbiter_if
  import sha_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) ();

  logic [N_REQ-1:0]              req_start;
  logic [N_REQ*HASH_BLOCK_W-1:0] req_data_in;
  logic [N_REQ-1:0]              req_message_length;
  logic [N_REQ-1:0]              req_done;
  logic [HASH_OUT_W-1:0]         req_data_out;
  logic [N_REQ-1:0]              req_pending;

  logic                          sha_start;
  logic [HASH_BLOCK_W-1:0]       sha_data_in;
  logic                          sha_message_length;
  logic [HASH_OUT_W-1:0]         sha_data_out;
  logic                          sha_done;

  logic [IDX_W-1:0]              grant_idx;
  logic                          busy;

  modport slave (
    input  req_start, req_data_in, req_message_length, sha_data_out, sha_done,
    output req_done, req_data_out, req_pending, sha_start, sha_data_in,
           sha_message_length, grant_idx, busy
  );

  modport master (
    output req_start, req_data_in, req_message_length, sha_data_out, sha_done,
    input  req_done, req_data_out, req_pending, sha_start, sha_data_in,
           sha_message_length, grant_idx, busy
  );

endinterface

// File: rtl/sha256_xmss_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first pending port at or
// above rr_ptr (with wrap) wins.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  // Scan from the farthest offset down so the closest pending port is written last.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (pending[(int'(rr_ptr) + k) % N_REQ]) begin
        valid  = 1'b1;
        winner = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/sha256_xmss_arbiter.sv
// Round-robin arbiter sharing one sha256XMSS core between N_REQ chain engines.
// Optional SHA_ARB_PERF_CNT_EN adds hash_count / wait_cycles counters.
module sha256_xmss_arbiter
  import sha_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  sha256_xmss_arbiter_if.slave  bus
`ifdef SHA_ARB_PERF_CNT_EN
  ,
  output logic [31:0]           hash_count,
  output logic [31:0]           wait_cycles
`endif
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_e              state_q;
  logic [N_REQ-1:0]        pending_q;
  logic [N_REQ-1:0]        pending_d;
  logic [N_REQ-1:0]        owned;
  logic [N_REQ-1:0]        set_eff;
  logic [N_REQ-1:0]        clr;
  logic [IDX_W-1:0]        grant_idx_q;
  logic [IDX_W-1:0]        rr_ptr_q;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_valid;
  logic [N_REQ-1:0]        req_done_q;
  logic [HASH_OUT_W-1:0]   req_data_out_q;
  logic                    sha_start_q;
  logic [HASH_BLOCK_W-1:0] sha_data_in_q;
  logic                    sha_len_q;

  rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
    .pending (pending_q),
    .rr_ptr  (rr_ptr_q),
    .valid   (pick_valid),
    .winner  (pick_idx)
  );

  // A start on a port that is already pending or owns the core is dropped.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_port
      assign owned[gi]     = (state_q != ST_IDLE) && (grant_idx_q == IDX_W'(gi));
      assign clr[gi]       = (state_q == ST_IDLE) && pick_valid && (pick_idx == IDX_W'(gi));
      assign set_eff[gi]   = bus.req_start[gi] && !pending_q[gi] && !owned[gi];
      assign pending_d[gi] = (pending_q[gi] && !clr[gi]) || set_eff[gi];
    end
  endgenerate

`ifdef SHA_ARB_PERF_CNT_EN
  logic [31:0] hash_count_q;
  logic [31:0] wait_cycles_q;
  assign hash_count  = hash_count_q;
  assign wait_cycles = wait_cycles_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      pending_q      <= '0;
      grant_idx_q    <= '0;
      rr_ptr_q       <= '0;
      req_done_q     <= '0;
      req_data_out_q <= '0;
      sha_start_q    <= 1'b0;
      sha_data_in_q  <= '0;
      sha_len_q      <= 1'b0;
`ifdef SHA_ARB_PERF_CNT_EN
      hash_count_q   <= '0;
      wait_cycles_q  <= '0;
`endif
    end else begin
      pending_q   <= pending_d;
      req_done_q  <= '0;
      sha_start_q <= 1'b0;
`ifdef SHA_ARB_PERF_CNT_EN
      if (state_q == ST_DONE) hash_count_q <= hash_count_q + 32'd1;
      if (state_q != ST_IDLE && pending_q != '0) wait_cycles_q <= wait_cycles_q + 32'd1;
`endif
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_idx_q   <= pick_idx;
            sha_data_in_q <= bus.req_data_in[pick_idx*HASH_BLOCK_W +: HASH_BLOCK_W];
            sha_len_q     <= bus.req_message_length[pick_idx];
            rr_ptr_q      <= IDX_W'(rr_next(int'(pick_idx), N_REQ));
            sha_start_q   <= 1'b1;
            state_q       <= ST_ISSUE;
          end
        end
        ST_ISSUE: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (bus.sha_done) begin
            req_data_out_q          <= bus.sha_data_out;
            req_done_q[grant_idx_q] <= 1'b1;
            state_q                 <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_done           = req_done_q;
  assign bus.req_data_out       = req_data_out_q;
  assign bus.req_pending        = pending_q;
  assign bus.sha_start          = sha_start_q;
  assign bus.sha_data_in        = sha_data_in_q;
  assign bus.sha_message_length = sha_len_q;
  assign bus.grant_idx          = grant_idx_q;
  assign bus.busy               = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sha256_xmss_arbiter.sv
// Scoreboard bench for sha256_xmss_arbiter with a fixed-latency core model;
// counter checks are compiled in when SHA_ARB_PERF_CNT_EN is defined.
module tb_sha256_xmss_arbiter;
  import sha_arb_pkg::*;

  localparam int N        = 4;
  localparam int CORE_LAT = 20;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sha256_xmss_arbiter_if #(.N_REQ(N)) bus ();

`ifdef SHA_ARB_PERF_CNT_EN
  logic [31:0] hash_count;
  logic [31:0] wait_cycles;
`endif

  sha256_xmss_arbiter #(.N_REQ(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef SHA_ARB_PERF_CNT_EN
    ,
    .hash_count  (hash_count),
    .wait_cycles (wait_cycles)
`endif
  );

  typedef struct {
    int           port;
    logic [255:0] dig;
  } exp_t;

  int              total = 0;
  int              bad   = 0;
  int              cyc   = 0;
  exp_t            exp_q[$];
  exp_t            mon_e;
  int              grant_log[$];
  int              start_log[$];
  int              done_log[$];
  int              sha_done_log[$];
  logic [1023:0]   blk_log[$];
  int              core_cnt;
  logic [1023:0]   core_blk;
  logic            core_len;
  logic            spur_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] dig_of(input logic [1023:0] b, input logic l);
    return {b[1023:896], b[127:0]} ^ {8{32'h9E3779B9}} ^ {255'b0, l};
  endfunction

  function automatic logic [1023:0] rnd_block();
    logic [1023:0] r;
    for (int w = 0; w < 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  // Core model: digest appears CORE_LAT cycles after the sha_start cycle.
  initial begin
    bus.sha_done     = 1'b0;
    bus.sha_data_out = '0;
    core_cnt         = 0;
    forever begin
      @(posedge clk);
      #2;
      bus.sha_done = spur_done;
      if (reset) begin
        core_cnt = 0;
      end else begin
        if (core_cnt > 0) begin
          core_cnt--;
          if (core_cnt == 0) begin
            bus.sha_done     = 1'b1;
            bus.sha_data_out = dig_of(core_blk, core_len);
          end
        end
        if (bus.sha_start) begin
          core_blk = bus.sha_data_in;
          core_len = bus.sha_message_length;
          core_cnt = CORE_LAT;
        end
      end
    end
  end

  // Monitor: logs starts and compares every completion against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.sha_start) begin
        start_log.push_back(cyc);
        grant_log.push_back(int'(bus.grant_idx));
        blk_log.push_back(bus.sha_data_in);
      end
      if (bus.sha_done) sha_done_log.push_back(cyc);
      if (bus.req_done !== '0) begin
        done_log.push_back(cyc);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL req_done_unexpected: got req_done=%b, required no completion", bus.req_done);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.req_done !== (N'(1) << mon_e.port) || bus.req_data_out !== mon_e.dig) begin
            bad++;
            $display("FAIL req_done_route: got mask=%b data=%h, required mask=%b data=%h",
                     bus.req_done, bus.req_data_out, N'(1) << mon_e.port, mon_e.dig);
          end else begin
            $display("txn cycle=%0d port=%0d digest=%h", cyc, mon_e.port, bus.req_data_out);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    exp_q.delete();
    grant_log.delete();
    start_log.delete();
    done_log.delete();
    sha_done_log.delete();
    blk_log.delete();
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.req_start = '0;
    repeat (3) step();
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic req(input int p, input logic [1023:0] b, input logic l, input bit push);
    bus.req_start[p]                 = 1'b1;
    bus.req_data_in[p*1024 +: 1024]  = b;
    bus.req_message_length[p]        = l;
    if (push) exp_q.push_back('{p, dig_of(b, l)});
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && !bus.busy && bus.req_pending == '0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_starts(input int n);
    for (int i = 0; i < 100 && start_log.size() < n; i++) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    @(negedge clk);
    total++;
    if ({bus.req_done, bus.req_pending, bus.sha_start, bus.sha_message_length, bus.busy} !== '0) begin
      bad++;
      $display("FAIL reset_ctrl: got done=%b pend=%b start=%b len=%b busy=%b, required all 0",
               bus.req_done, bus.req_pending, bus.sha_start, bus.sha_message_length, bus.busy);
    end
    total++;
    if (bus.req_data_out !== '0 || bus.sha_data_in !== '0) begin
      bad++;
      $display("FAIL reset_data: got req_data_out/sha_data_in nonzero, required 0");
    end
    total++;
    if (bus.grant_idx !== '0) begin
      bad++;
      $display("FAIL reset_grant: got %0d, required 0", bus.grant_idx);
    end
`ifdef SHA_ARB_PERF_CNT_EN
    total++;
    if (hash_count !== 32'd0 || wait_cycles !== 32'd0) begin
      bad++;
      $display("FAIL reset_counters: got %0d/%0d, required 0/0", hash_count, wait_cycles);
    end
`endif
    step();
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic test_single();
    logic [1023:0] blk;
    int t0;
    bit ok;
    do_reset();
    blk = {{85{12'hABC}}, 4'hA};
    t0  = cyc;
    req(2, blk, 1'b1, 1'b1);
    step();
    bus.req_start = '0;
    @(negedge clk);
    total++;
    if (bus.req_pending !== 4'b0100) begin
      bad++;
      $display("FAIL single_pending: got %b, required 0100", bus.req_pending);
    end
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_timeout: got no completion, required drain"); end
    total++;
    if (start_log.size() != 1 || start_log[0] != t0 + 2) begin
      bad++;
      $display("FAIL single_start_time: got %0d starts first@%0d, required 1 start @%0d",
               start_log.size(), (start_log.size() > 0) ? start_log[0] : -1, t0 + 2);
    end
    total++;
    if (blk_log.size() != 1 || blk_log[0] !== blk || grant_log[0] != 2) begin
      bad++;
      $display("FAIL single_block: got grant=%0d block mismatch, required grant=2 port-2 block",
               (grant_log.size() > 0) ? grant_log[0] : -1);
    end
    total++;
    if (done_log.size() != 1 || sha_done_log.size() < 1 || done_log[0] != sha_done_log[0] + 1
        || sha_done_log[0] != t0 + 2 + CORE_LAT) begin
      bad++;
      $display("FAIL single_done_time: got done@%0d sha_done@%0d, required %0d/%0d",
               (done_log.size() > 0) ? done_log[0] : -1, (sha_done_log.size() > 0) ? sha_done_log[0] : -1,
               t0 + 3 + CORE_LAT, t0 + 2 + CORE_LAT);
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    bit order_ok;
    do_reset();
    for (int p = 0; p < N; p++) req(p, rnd_block(), 1'($urandom_range(0, 1)), 1'b1);
    step();
    bus.req_start = '0;
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL simul_timeout: got pending work, required drain"); end
    order_ok = (grant_log.size() == 4);
    for (int k = 0; k < grant_log.size() && k < 4; k++) if (grant_log[k] != k) order_ok = 1'b0;
    total++;
    if (!order_ok) begin
      bad++;
      $display("FAIL simul_order: got %0d grants, required order 0,1,2,3", grant_log.size());
    end
`ifdef SHA_ARB_PERF_CNT_EN
    total++;
    if (hash_count !== 32'd4 || wait_cycles !== 32'd66) begin
      bad++;
      $display("FAIL simul_counters: got %0d/%0d, required 4/66", hash_count, wait_cycles);
    end
`endif
  endtask

  task automatic test_fairness();
    int  n0;
    int  n3;
    bit  fair;
    bit  ok;
    logic [N-1:0] d;
    do_reset();
    n0 = 1;
    n3 = 1;
    ok = 1'b0;
    req(0, rnd_block(), 1'b0, 1'b1);
    req(3, rnd_block(), 1'b1, 1'b1);
    step();
    bus.req_start = '0;
    for (int i = 0; i < 3000; i++) begin
      if (n0 == 10 && n3 == 10 && exp_q.size() == 0 && !bus.busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      d = bus.req_done;
      step();
      bus.req_start = '0;
      if (d[0] && n0 < 10) begin req(0, rnd_block(), 1'b0, 1'b1); n0++; end
      if (d[3] && n3 < 10) begin req(3, rnd_block(), 1'b1, 1'b1); n3++; end
    end
    bus.req_start = '0;
    total++;
    if (!ok) begin bad++; $display("FAIL fair_timeout: got %0d/%0d issued, required 10/10", n0, n3); end
    fair = (grant_log.size() == 20);
    for (int k = 0; k < grant_log.size(); k++) if (grant_log[k] != ((k % 2 == 0) ? 0 : 3)) fair = 1'b0;
    total++;
    if (!fair) begin
      bad++;
      $display("FAIL fair_alternate: got %0d grants not alternating, required 20 as 0,3,0,3", grant_log.size());
    end
  endtask

  task automatic test_late_arrival();
    bit ok;
    do_reset();
    req(0, rnd_block(), 1'b0, 1'b1);
    step();
    bus.req_start = '0;
    wait_starts(1);
    repeat (5) step();
    req(1, rnd_block(), 1'b1, 1'b1);
    step();
    bus.req_start = '0;
    @(negedge clk);
    total++;
    if (bus.req_pending !== 4'b0010 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL late_pending: got pend=%b busy=%b, required 0010/1", bus.req_pending, bus.busy);
    end
    drain(ok);
    total++;
    if (!ok || start_log.size() != 2 || done_log.size() != 2 || start_log[1] != done_log[0] + 2
        || grant_log[1] != 1) begin
      bad++;
      $display("FAIL late_b2b: got %0d starts, second@%0d, required port 1 start @%0d",
               start_log.size(), (start_log.size() > 1) ? start_log[1] : -1,
               (done_log.size() > 0) ? done_log[0] + 2 : -1);
    end
  endtask

  task automatic test_reset_mid_hash();
    do_reset();
    for (int p = 0; p < 3; p++) req(p, rnd_block(), 1'b0, 1'b1);
    step();
    bus.req_start = '0;
    wait_starts(1);
    repeat (5) step();
    @(negedge clk);
    total++;
    if (bus.req_pending !== 4'b0110) begin
      bad++;
      $display("FAIL midrst_pre: got pend=%b, required 0110", bus.req_pending);
    end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    total++;
    if ({bus.req_pending, bus.busy, bus.req_done, bus.sha_start, bus.grant_idx} !== '0
        || bus.sha_data_in !== '0) begin
      bad++;
      $display("FAIL midrst_state: got pend=%b busy=%b done=%b start=%b grant=%0d, required all 0",
               bus.req_pending, bus.busy, bus.req_done, bus.sha_start, bus.grant_idx);
    end
    repeat (60) step();
    total++;
    if (start_log.size() != 1 || done_log.size() != 0) begin
      bad++;
      $display("FAIL midrst_quiet: got %0d starts %0d dones, required 1/0", start_log.size(), done_log.size());
    end
  endtask

  task automatic test_protocol_error();
    logic [1023:0] b0;
    bit ok;
    do_reset();
    b0 = rnd_block();
    req(0, b0, 1'b0, 1'b1);
    step();
    req(0, b0, 1'b0, 1'b0);
    step();
    bus.req_start = '0;
    wait_starts(1);
    repeat (5) step();
    req(0, b0, 1'b0, 1'b0);
    step();
    bus.req_start = '0;
    drain(ok);
    repeat (10) step();
    total++;
    if (!ok || start_log.size() != 1 || done_log.size() != 1 || bus.req_pending !== '0) begin
      bad++;
      $display("FAIL proto_single: got %0d starts %0d dones pend=%b, required 1/1/0000",
               start_log.size(), done_log.size(), bus.req_pending);
    end
`ifdef SHA_ARB_PERF_CNT_EN
    total++;
    if (hash_count !== 32'd1) begin
      bad++;
      $display("FAIL proto_count: got %0d, required 1", hash_count);
    end
`endif
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    repeat (4) step();
    total++;
    if (bus.busy !== 1'b0 || done_log.size() != 1 || start_log.size() != 1) begin
      bad++;
      $display("FAIL stray_done: got busy=%b dones=%0d, required 0/1", bus.busy, done_log.size());
    end
  endtask

  initial begin
    bus.req_start          = '0;
    bus.req_data_in        = '0;
    bus.req_message_length = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_late_arrival();
    test_reset_mid_hash();
    test_protocol_error();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no end of run, required finish within 1 ms");
    $fatal(1, "bench did not finish");
  end

endmodule
